etx_byte_serializer: RTL

Transmit-path stage directly downstream of the etx protocol stage. Captures one registered emesh packet (tx_packet/tx_access/tx_burst), serializes it MSB-first into a byte stream toward the IO/link layer, and back-pressures the protocol stage through tx_io_wait. Back-to-back double-write bursts are sent as 8-byte continuation beats inside one frame, with no header and no address.

---
 rtl/elink_pkg.sv | 23 ++
 rtl/packet2emesh.sv | 25 ++
 rtl/etx_byte_serializer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/elink_pkg.sv
// Shared elink definitions: packet geometry, serializer byte indices and state encoding.
package elink_pkg;

  localparam int PW = 104;
  localparam int AW = 32;

  localparam logic [3:0] HDR_IDX  = 4'd0;
  localparam logic [3:0] DST_IDX  = 4'd1;
  localparam logic [3:0] DATA_IDX = 4'd5;
  localparam logic [3:0] SRC_IDX  = 4'd9;
  localparam logic [3:0] LAST_IDX = 4'd12;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Byte sel of a 32-bit word, sel 0 being the most significant byte.
  function automatic logic [7:0] word_byte(input logic [AW-1:0] word, input logic [1:0] sel);
    return word[8*(3-int'(sel)) +: 8];
  endfunction

endpackage

// File: rtl/packet2emesh.sv
// Splits a flat emesh packet into its named fields.
module packet2emesh
  import elink_pkg::*;
(
  input  logic [PW-1:0] packet,
  output logic          write,
  output logic [1:0]    datamode,
  output logic [3:0]    ctrlmode,
  output logic [AW-1:0] dstaddr,
  output logic [AW-1:0] data,
  output logic [AW-1:0] srcaddr
);

  // Bit 3 is reserved in the packet layout.
  logic unused_rsvd;

  assign write       = packet[0];
  assign datamode    = packet[2:1];
  assign unused_rsvd = packet[3];
  assign ctrlmode    = packet[7:4];
  assign dstaddr     = packet[39:8];
  assign data        = packet[71:40];
  assign srcaddr     = packet[103:72];

endmodule

// File: rtl/etx_byte_serializer.sv
// Serializes one emesh packet MSB-first into a byte stream; double-write bursts
// continue the current frame with 8-byte data/srcaddr beats.
module etx_byte_serializer
  import elink_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] tx_packet,
  input  logic          tx_access,
  input  logic          tx_burst,
  output logic          tx_io_wait,
  output logic [7:0]    lnk_data,
  output logic          lnk_valid,
  output logic          lnk_first,
  output logic          lnk_frame,
  input  logic          lnk_wait
);

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [PW-1:0] shadow_q, shadow_d;
  logic          first_d, frame_d, valid_d;
  logic [7:0]    byte_d;
  logic          cap, consume;

  logic          f_write;
  logic [1:0]    f_datamode;
  logic [3:0]    f_ctrlmode;
  logic [AW-1:0] f_dstaddr, f_data, f_srcaddr;

  // The last byte can hand over to a new packet in the same edge, so the stall
  // drops there unless the link itself is stalled.
  assign tx_io_wait = lnk_valid & ~((idx_q == LAST_IDX) & ~lnk_wait);
  assign cap        = ~tx_io_wait & tx_access;
  assign consume    = lnk_valid & ~lnk_wait;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    first_d  = lnk_first;
    frame_d  = lnk_frame;
    valid_d  = lnk_valid;
    case (state_q)
      IDLE: begin
        if (cap) begin
          state_d  = SEND;
          idx_d    = HDR_IDX;
          shadow_d = tx_packet;
          first_d  = 1'b1;
          frame_d  = 1'b1;
          valid_d  = 1'b1;
        end
      end
      SEND: begin
        if (consume) begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 4'd1;
            first_d = 1'b0;
          end else if (cap) begin
            shadow_d = tx_packet;
            idx_d    = tx_burst ? DATA_IDX : HDR_IDX;
            first_d  = ~tx_burst;
          end else begin
            state_d = IDLE;
            idx_d   = HDR_IDX;
            first_d = 1'b0;
            frame_d = 1'b0;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fields are taken from the next shadow value so lnk_data can be registered
  // in the same edge that moves idx.
  packet2emesh u_p2e (
    .packet   (shadow_d),
    .write    (f_write),
    .datamode (f_datamode),
    .ctrlmode (f_ctrlmode),
    .dstaddr  (f_dstaddr),
    .data     (f_data),
    .srcaddr  (f_srcaddr)
  );

  always_comb begin
    byte_d = 8'h00;
    if (idx_d == HDR_IDX)
      byte_d = {f_ctrlmode, f_datamode, f_write, 1'b0};
    else if (idx_d < DATA_IDX)
      byte_d = word_byte(f_dstaddr, 2'(idx_d - DST_IDX));
    else if (idx_d < SRC_IDX)
      byte_d = word_byte(f_data, 2'(idx_d - DATA_IDX));
    else if (idx_d <= LAST_IDX)
      byte_d = word_byte(f_srcaddr, 2'(idx_d - SRC_IDX));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= HDR_IDX;
      lnk_data  <= 8'h00;
      lnk_valid <= 1'b0;
      lnk_first <= 1'b0;
      lnk_frame <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lnk_data  <= valid_d ? byte_d : 8'h00;
      lnk_valid <= valid_d;
      lnk_first <= first_d;
      lnk_frame <= frame_d;
    end
  end

  // NOTE: the shadow register is pure data qualified by lnk_valid, so it has no reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

endmodule
